// File: rtl/jimmy_port_monitor_if.sv
// rtl/jimmy_port_monitor_if.sv - port bundle between the jimmy core, the port monitor and the log reader
//
// Purpose: groups the core output strobe/data bus, the stimulus value and the
//          show-ahead log read port of jimmy_port_monitor.
// Optional feature macro: JIMMY_MON_TIMESTAMP_EN (adds TS_W and log_time).
// Signals:
//   out_strobe [CHANNELS]   core -> monitor, per-channel write strobe
//   out_data   [DATA_W]     core -> monitor, shared output data
//   stim_data  [DATA_W]     monitor -> core, stimulus value
//   log_pop                 reader -> monitor, consume head entry
//   log_valid               monitor -> reader, FIFO not empty
//   log_chan   [CW]         monitor -> reader, head channel
//   log_data   [DATA_W]     monitor -> reader, head data
//   log_level  [LW]         monitor -> reader, entries held
//   overflow                monitor -> reader, sticky entry-lost flag
//   drop_count [8]          monitor -> reader, saturating lost-entry count
//   log_time   [TS_W]       monitor -> reader, head timestamp (macro only)
interface jimmy_port_monitor_if #(
  parameter int DATA_W   = 8,
  parameter int CHANNELS = 4,
  parameter int DEPTH    = 8
`ifdef JIMMY_MON_TIMESTAMP_EN
  , parameter int TS_W   = 16
`endif
);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int LW = $clog2(DEPTH) + 1;

  logic [CHANNELS-1:0] out_strobe;
  logic [DATA_W-1:0]   out_data;
  logic [DATA_W-1:0]   stim_data;
  logic                log_pop;
  logic                log_valid;
  logic [CW-1:0]       log_chan;
  logic [DATA_W-1:0]   log_data;
  logic [LW-1:0]       log_level;
  logic                overflow;
  logic [7:0]          drop_count;
`ifdef JIMMY_MON_TIMESTAMP_EN
  logic [TS_W-1:0]     log_time;

  modport master (
    input  out_strobe, out_data, log_pop,
    output stim_data, log_valid, log_chan, log_data, log_level,
           overflow, drop_count, log_time
  );
  modport slave (
    output out_strobe, out_data, log_pop,
    input  stim_data, log_valid, log_chan, log_data, log_level,
           overflow, drop_count, log_time
  );
`else
  modport master (
    input  out_strobe, out_data, log_pop,
    output stim_data, log_valid, log_chan, log_data, log_level,
           overflow, drop_count
  );
  modport slave (
    output out_strobe, out_data, log_pop,
    input  stim_data, log_valid, log_chan, log_data, log_level,
           overflow, drop_count
  );
`endif
endinterface

// File: rtl/jimmy_port_monitor.sv
// rtl/jimmy_port_monitor.sv - logs completed strobe writes of the jimmy core into a show-ahead FIFO
//
// Purpose: detects the falling edge of each out_strobe line, logs (channel, data)
//          of the lowest falling channel, counts the rest as drops, and advances
//          a stimulus value on every completed write of STIM_CHAN.
// Optional feature macro: JIMMY_MON_TIMESTAMP_EN (per-entry cycle timestamp, log_time).
// Ports:
//   jimmy_clk  system clock, rising edge
//   reset      asynchronous, active-high
//   bus        jimmy_port_monitor_if.master (strobe/data in, stimulus and log out)
module jimmy_port_monitor #(
  parameter int DATA_W    = 8,
  parameter int CHANNELS  = 4,
  parameter int DEPTH     = 8,
  parameter int STIM_CHAN = 1,
  parameter int STIM_INIT = 0,
  parameter int STIM_STEP = 1
`ifdef JIMMY_MON_TIMESTAMP_EN
  , parameter int TS_W    = 16
`endif
) (
  input  logic                   jimmy_clk,
  input  logic                   reset,
  jimmy_port_monitor_if.master   bus
);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [CHANNELS-1:0] r_strobe_q;
  logic [DATA_W-1:0]   r_data_q;
  logic [CW-1:0]       r_mem_chan [DEPTH];
  logic [DATA_W-1:0]   r_mem_data [DEPTH];
  logic [LW-1:0]       r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]       r_log_chan;
  logic [DATA_W-1:0]   r_log_data;
  logic [DATA_W-1:0]   r_stim;
  logic                r_overflow;
  logic [7:0]          r_drop_count;

  logic [CHANNELS-1:0] w_fall;
  logic                w_any_fall;
  logic [CW-1:0]       w_push_chan;
  logic [4:0]          w_nfalls;
  logic [4:0]          w_drops;
  logic [8:0]          w_drop_sum;
  logic [LW-1:0]       w_level;
  logic [LW-1:0]       w_rd_next;
  logic                w_empty, w_full, w_pop_ok, w_push_ok;

  always_comb begin
    w_fall      = r_strobe_q & ~bus.out_strobe;
    w_any_fall  = |w_fall;
    w_push_chan = '0;
    w_nfalls    = '0;
    // Descending scan so the lowest falling index wins.
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (w_fall[i]) w_push_chan = CW'(i);
    end
    for (int i = 0; i < CHANNELS; i++) begin
      w_nfalls = w_nfalls + 5'(w_fall[i]);
    end
    w_level   = r_wr_ptr - r_rd_ptr;
    w_rd_next = r_rd_ptr + LW'(1);
    w_empty   = (r_wr_ptr == r_rd_ptr);
    w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    w_pop_ok  = bus.log_pop && !w_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    w_push_ok = w_any_fall && (!w_full || w_pop_ok);
    w_drops   = w_nfalls - {4'b0, w_push_ok};
    w_drop_sum = {1'b0, r_drop_count} + {4'b0, w_drops};
  end

  // Storage carries no reset; the pointers define what is valid.
  always_ff @(posedge jimmy_clk) begin
    if (w_push_ok) begin
      r_mem_chan[r_wr_ptr[AW-1:0]] <= w_push_chan;
      r_mem_data[r_wr_ptr[AW-1:0]] <= r_data_q;
    end
  end

  always_ff @(posedge jimmy_clk or posedge reset) begin
    if (reset) begin
      r_strobe_q   <= '0;
      r_data_q     <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_log_chan   <= '0;
      r_log_data   <= '0;
      r_stim       <= DATA_W'(STIM_INIT);
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else begin
      r_strobe_q <= bus.out_strobe;
      r_data_q   <= bus.out_data;
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + LW'(1);
      if (w_pop_ok)  r_rd_ptr <= w_rd_next;
      // Head register: next stored entry, or the bypassed push when the
      // FIFO is (or becomes) otherwise empty; holds when nothing follows.
      if (w_pop_ok) begin
        if (w_level > LW'(1)) begin
          r_log_chan <= r_mem_chan[w_rd_next[AW-1:0]];
          r_log_data <= r_mem_data[w_rd_next[AW-1:0]];
        end else if (w_push_ok) begin
          r_log_chan <= w_push_chan;
          r_log_data <= r_data_q;
        end
      end else if (w_empty && w_push_ok) begin
        r_log_chan <= w_push_chan;
        r_log_data <= r_data_q;
      end
      if (w_fall[STIM_CHAN]) r_stim <= r_stim + DATA_W'(STIM_STEP);
      if (w_drops != 5'd0) r_overflow <= 1'b1;
      r_drop_count <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
    end
  end

`ifdef JIMMY_MON_TIMESTAMP_EN
  logic [TS_W-1:0] r_ts;
  logic [TS_W-1:0] r_mem_time [DEPTH];
  logic [TS_W-1:0] r_log_time;

  always_ff @(posedge jimmy_clk) begin
    if (w_push_ok) r_mem_time[r_wr_ptr[AW-1:0]] <= r_ts;
  end

  always_ff @(posedge jimmy_clk or posedge reset) begin
    if (reset) begin
      r_ts       <= '0;
      r_log_time <= '0;
    end else begin
      r_ts <= r_ts + TS_W'(1);
      if (w_pop_ok) begin
        if (w_level > LW'(1)) r_log_time <= r_mem_time[w_rd_next[AW-1:0]];
        else if (w_push_ok)   r_log_time <= r_ts;
      end else if (w_empty && w_push_ok) begin
        r_log_time <= r_ts;
      end
    end
  end

  assign bus.log_time = r_log_time;
`endif

  assign bus.stim_data  = r_stim;
  assign bus.log_valid  = !w_empty;
  assign bus.log_chan   = r_log_chan;
  assign bus.log_data   = r_log_data;
  assign bus.log_level  = w_level;
  assign bus.overflow   = r_overflow;
  assign bus.drop_count = r_drop_count;
endmodule

// File: tb/tb_jimmy_port_monitor.sv
// tb/tb_jimmy_port_monitor.sv - scoreboard bench for jimmy_port_monitor
module tb_jimmy_port_monitor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  jimmy_port_monitor_if #(.DATA_W(8), .CHANNELS(4), .DEPTH(8)) bus ();

  jimmy_port_monitor #(
    .DATA_W(8), .CHANNELS(4), .DEPTH(8),
    .STIM_CHAN(1), .STIM_INIT(0), .STIM_STEP(1)
  ) dut (
    .jimmy_clk (clk),
    .reset     (rst),
    .bus       (bus)
  );

  typedef struct {
    logic [1:0] ch;
    logic [7:0] d;
  } ent_t;

  ent_t sb[$];
  ent_t e;
  int total = 0;
  int bad = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    bus.out_strobe = '0;
    bus.out_data = '0;
    bus.log_pop = 1'b0;
    tick;
    tick;
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset;
    do_reset;
    repeat (20) tick;
    total++; if (bus.log_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0h want=0", bus.log_valid); end
    total++; if (bus.log_level !== 4'd0) begin bad++; $display("FAIL reset_level got=%0d want=0", bus.log_level); end
    total++; if (bus.stim_data !== 8'h00) begin bad++; $display("FAIL reset_stim got=%0h want=0", bus.stim_data); end
    total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%0h want=0", bus.overflow); end
    total++; if (bus.drop_count !== 8'd0) begin bad++; $display("FAIL reset_drops got=%0d want=0", bus.drop_count); end
    total++; if (bus.log_data !== 8'h00 || bus.log_chan !== 2'd0) begin bad++; $display("FAIL reset_head got=%0h/%0h want=0/0", bus.log_chan, bus.log_data); end
  endtask

  task automatic test_single;
    do_reset;
    bus.out_data = 8'h18;
    bus.out_strobe = 4'b0010;
    repeat (3) tick;
    bus.out_strobe = 4'b0000;
    sb.push_back('{ch: 2'd1, d: 8'h18});
    total++; if (bus.log_valid !== 1'b0) begin bad++; $display("FAIL single_latency got=%0h want=0", bus.log_valid); end
    tick;
    e = sb.pop_front();
    total++; if (bus.log_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%0h want=1", bus.log_valid); end
    total++; if (bus.log_chan !== e.ch || bus.log_data !== e.d) begin bad++; $display("FAIL single_head got=%0h/%0h want=%0h/%0h", bus.log_chan, bus.log_data, e.ch, e.d); end
    total++; if (bus.stim_data !== 8'h01) begin bad++; $display("FAIL single_stim got=%0h want=1", bus.stim_data); end
    bus.log_pop = 1'b1;
    tick;
    bus.log_pop = 1'b0;
    total++; if (bus.log_valid !== 1'b0) begin bad++; $display("FAIL single_pop got=%0h want=0", bus.log_valid); end
    total++; if (bus.log_data !== e.d) begin bad++; $display("FAIL single_hold got=%0h want=%0h", bus.log_data, e.d); end
  endtask

  task automatic test_simultaneous;
    do_reset;
    bus.out_data = 8'h05;
    bus.out_strobe = 4'b0101;
    tick;
    bus.out_strobe = 4'b0000;
    sb.push_back('{ch: 2'd0, d: 8'h05});
    tick;
    e = sb.pop_front();
    total++; if (bus.log_chan !== e.ch || bus.log_data !== e.d) begin bad++; $display("FAIL simul_head got=%0h/%0h want=%0h/%0h", bus.log_chan, bus.log_data, e.ch, e.d); end
    total++; if (bus.log_level !== 4'd1) begin bad++; $display("FAIL simul_level got=%0d want=1", bus.log_level); end
    total++; if (bus.drop_count !== 8'd1) begin bad++; $display("FAIL simul_drops got=%0d want=1", bus.drop_count); end
    total++; if (bus.overflow !== 1'b1) begin bad++; $display("FAIL simul_overflow got=%0h want=1", bus.overflow); end
    total++; if (bus.stim_data !== 8'h00) begin bad++; $display("FAIL simul_stim got=%0h want=0", bus.stim_data); end
    bus.log_pop = 1'b1;
    tick;
    tick;
    bus.log_pop = 1'b0;
    total++; if (bus.log_level !== 4'd0 || bus.log_valid !== 1'b0) begin bad++; $display("FAIL empty_pop got=%0d/%0h want=0/0", bus.log_level, bus.log_valid); end
    total++; if (bus.log_data !== 8'h05 || bus.drop_count !== 8'd1) begin bad++; $display("FAIL empty_pop_state got=%0h/%0d want=5/1", bus.log_data, bus.drop_count); end
  endtask

  task automatic test_full;
    int exp_drop;
    exp_drop = 0;
    do_reset;
    for (int i = 0; i < 9; i++) begin
      bus.out_data = 8'h30 + 8'(i);
      bus.out_strobe = 4'b1000;
      tick;
      bus.out_strobe = 4'b0000;
      if (sb.size() < 8) sb.push_back('{ch: 2'd3, d: bus.out_data});
      else exp_drop++;
      tick;
    end
    total++; if (bus.log_level !== 4'(sb.size())) begin bad++; $display("FAIL full_level got=%0d want=%0d", bus.log_level, sb.size()); end
    total++; if (bus.drop_count !== 8'(exp_drop)) begin bad++; $display("FAIL full_drops got=%0d want=%0d", bus.drop_count, exp_drop); end
    total++; if (bus.log_data !== sb[0].d) begin bad++; $display("FAIL full_head got=%0h want=%0h", bus.log_data, sb[0].d); end
    bus.out_data = 8'h40;
    bus.out_strobe = 4'b1000;
    tick;
    bus.out_strobe = 4'b0000;
    bus.log_pop = 1'b1;
    void'(sb.pop_front());
    sb.push_back('{ch: 2'd3, d: 8'h40});
    tick;
    bus.log_pop = 1'b0;
    total++; if (bus.log_level !== 4'd8) begin bad++; $display("FAIL full_pushpop_level got=%0d want=8", bus.log_level); end
    total++; if (bus.drop_count !== 8'(exp_drop)) begin bad++; $display("FAIL full_pushpop_drops got=%0d want=%0d", bus.drop_count, exp_drop); end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      total++; if (bus.log_valid !== 1'b1 || bus.log_chan !== e.ch || bus.log_data !== e.d) begin bad++; $display("FAIL full_drain got=%0h/%0h/%0h want=1/%0h/%0h", bus.log_valid, bus.log_chan, bus.log_data, e.ch, e.d); end
      bus.log_pop = 1'b1;
      tick;
      bus.log_pop = 1'b0;
    end
    total++; if (bus.log_valid !== 1'b0) begin bad++; $display("FAIL full_drained got=%0h want=0", bus.log_valid); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp_stim;
    exp_stim = 8'h00;
    do_reset;
    for (int i = 0; i < 256; i++) begin
      bus.out_data = 8'(i * 7 + 3);
      bus.out_strobe = 4'b0010;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        total++; if (bus.log_data !== e.d || bus.log_chan !== e.ch) begin bad++; $display("FAIL b2b_head got=%0h/%0h want=%0h/%0h", bus.log_chan, bus.log_data, e.ch, e.d); end
        bus.log_pop = 1'b1;
      end
      tick;
      bus.log_pop = 1'b0;
      bus.out_strobe = 4'b0000;
      sb.push_back('{ch: 2'd1, d: bus.out_data});
      exp_stim = exp_stim + 8'd1;
      tick;
    end
    total++; if (bus.stim_data !== exp_stim) begin bad++; $display("FAIL b2b_stim got=%0h want=%0h", bus.stim_data, exp_stim); end
    total++; if (bus.drop_count !== 8'd0 || bus.overflow !== 1'b0) begin bad++; $display("FAIL b2b_drops got=%0d/%0h want=0/0", bus.drop_count, bus.overflow); end
    total++; if (bus.log_level !== 4'(sb.size())) begin bad++; $display("FAIL b2b_level got=%0d want=%0d", bus.log_level, sb.size()); end
  endtask

  task automatic test_reset_mid;
    do_reset;
    for (int i = 0; i < 5; i++) begin
      bus.out_data = 8'h60 + 8'(i);
      bus.out_strobe = 4'b0010;
      tick;
      bus.out_strobe = 4'b0000;
      sb.push_back('{ch: 2'd1, d: bus.out_data});
      tick;
    end
    total++; if (bus.log_level !== 4'(sb.size())) begin bad++; $display("FAIL mid_level got=%0d want=%0d", bus.log_level, sb.size()); end
    total++; if (bus.stim_data !== 8'd5) begin bad++; $display("FAIL mid_stim got=%0h want=5", bus.stim_data); end
    rst = 1'b1;
    sb.delete();
    #1;
    total++; if (bus.log_valid !== 1'b0 || bus.log_level !== 4'd0) begin bad++; $display("FAIL mid_async got=%0h/%0d want=0/0", bus.log_valid, bus.log_level); end
    total++; if (bus.stim_data !== 8'h00) begin bad++; $display("FAIL mid_async_stim got=%0h want=0", bus.stim_data); end
    bus.out_strobe = 4'b0010;
    tick;
    rst = 1'b0;
    bus.out_strobe = 4'b0000;
    tick;
    tick;
    total++; if (bus.log_valid !== 1'b0 || bus.stim_data !== 8'h00) begin bad++; $display("FAIL release_strobe got=%0h/%0h want=0/0", bus.log_valid, bus.stim_data); end
  endtask

`ifdef JIMMY_MON_TIMESTAMP_EN
  task automatic test_timestamp;
    rst = 1'b1;
    bus.out_strobe = '0;
    bus.log_pop = 1'b0;
    tick;
    rst = 1'b0;
    repeat (9) tick;
    bus.out_strobe = 4'b0001;
    tick;
    bus.out_strobe = 4'b0000;
    tick;
    repeat (13) tick;
    bus.out_strobe = 4'b0001;
    tick;
    bus.out_strobe = 4'b0000;
    tick;
    total++; if (bus.log_time !== 16'd10) begin bad++; $display("FAIL ts_first got=%0d want=10", bus.log_time); end
    bus.log_pop = 1'b1;
    tick;
    bus.log_pop = 1'b0;
    total++; if (bus.log_time !== 16'd25) begin bad++; $display("FAIL ts_second got=%0d want=25", bus.log_time); end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bus.out_strobe = '0;
    bus.out_data = '0;
    bus.log_pop = 1'b0;
    test_reset;
    test_single;
    test_simultaneous;
    test_full;
    test_back_to_back;
    test_reset_mid;
`ifdef JIMMY_MON_TIMESTAMP_EN
    test_timestamp;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
